// File: rtl/ibex_load_store_resp.sv
// rtl/ibex_load_store_resp.sv - LSU response tracker: split handling, load alignment/extension, completion pulse
// Optional IBEX_LOAD_STORE_RESP_PERF_EN adds saturating perf_loads_o / perf_split_o counters.
module ibex_load_store_resp #(
  parameter logic MisalignedEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic [4:0]  req_waddr_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        lsu_data_valid_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        load_err_o,
  output logic        store_err_o,
`ifdef IBEX_LOAD_STORE_RESP_PERF_EN
  output logic [31:0] perf_loads_o,
  output logic [31:0] perf_split_o,
`endif
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT_ONLY, WAIT_1, WAIT_2} state_e;

  state_e      r_state;
  logic        r_we;
  logic [1:0]  r_type;
  logic        r_sign;
  logic [1:0]  r_offset;
  logic [4:0]  r_waddr;
  logic [31:0] r_hold;
  logic        r_err;

  logic        w_req_split;
  logic [4:0]  w_lo_shift;
  logic [5:0]  w_hi_shift;
  logic [31:0] w_rot;
  logic [31:0] w_data;
  logic [31:0] w_ext;
  logic        w_err;

  assign w_req_split = ((req_type_i == 2'b00) && (req_offset_i != 2'b00)) ||
                       ((req_type_i == 2'b01) && (req_offset_i == 2'b11));

  // Second response supplies the upper bytes that the first word could not.
  assign w_lo_shift = {r_offset, 3'b000};
  assign w_hi_shift = 6'd32 - {1'b0, w_lo_shift};
  assign w_rot      = data_rdata_i >> w_lo_shift;
  assign w_data     = (r_state == WAIT_2) ? (r_hold | (data_rdata_i << w_hi_shift)) : w_rot;
  assign w_err      = r_err | data_err_i;

  always_comb begin
    w_ext = w_data;
    case (r_type)
      2'b00:   w_ext = w_data;
      2'b01:   w_ext = {{16{r_sign & w_data[15]}}, w_data[15:0]};
      default: w_ext = {{24{r_sign & w_data[7]}}, w_data[7:0]};
    endcase
  end

  assign ready_o = (r_state == IDLE);
  assign busy_o  = ~ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state          <= IDLE;
      r_we             <= 1'b0;
      r_type           <= 2'b00;
      r_sign           <= 1'b0;
      r_offset         <= 2'b00;
      r_waddr          <= 5'd0;
      r_hold           <= 32'd0;
      r_err            <= 1'b0;
      lsu_data_valid_o <= 1'b0;
      rf_we_o          <= 1'b0;
      rf_waddr_o       <= 5'd0;
      rf_wdata_o       <= 32'd0;
      load_err_o       <= 1'b0;
      store_err_o      <= 1'b0;
`ifdef IBEX_LOAD_STORE_RESP_PERF_EN
      perf_loads_o     <= 32'd0;
      perf_split_o     <= 32'd0;
`endif
    end else begin
      lsu_data_valid_o <= 1'b0;
      rf_we_o          <= 1'b0;
      load_err_o       <= 1'b0;
      store_err_o      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_we     <= req_we_i;
            r_type   <= req_type_i;
            r_sign   <= req_sign_ext_i;
            r_offset <= req_offset_i;
            r_waddr  <= req_waddr_i;
            // Without split support a two-transaction access is an error up front.
            r_err    <= w_req_split & ~MisalignedEn;
            r_state  <= (w_req_split && MisalignedEn) ? WAIT_1 : WAIT_ONLY;
          end
        end
        WAIT_1: begin
          if (data_rvalid_i) begin
            r_hold  <= w_rot;
            r_err   <= w_err;
            r_state <= WAIT_2;
          end
        end
        default: begin
          if (data_rvalid_i) begin
            lsu_data_valid_o <= 1'b1;
            rf_we_o          <= ~r_we & ~w_err;
            load_err_o       <= ~r_we & w_err;
            store_err_o      <= r_we & w_err;
            rf_waddr_o       <= r_waddr;
            rf_wdata_o       <= w_ext;
            r_state          <= IDLE;
`ifdef IBEX_LOAD_STORE_RESP_PERF_EN
            if (!r_we && !w_err && (perf_loads_o != 32'hFFFF_FFFF))
              perf_loads_o <= perf_loads_o + 32'd1;
            if ((r_state == WAIT_2) && (perf_split_o != 32'hFFFF_FFFF))
              perf_split_o <= perf_split_o + 32'd1;
`endif
          end
        end
      endcase
    end
  end

  a_req_when_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) req_valid_i |-> ready_o)
    else $warning("req_valid_i while busy is ignored");
  a_rvalid_when_idle: assert property (@(posedge clk_i) disable iff (!rst_ni) data_rvalid_i |-> !ready_o)
    else $warning("data_rvalid_i while idle is ignored");

endmodule

// File: tb/tb_ibex_load_store_resp.sv
// tb/tb_ibex_load_store_resp.sv - bench for ibex_load_store_resp: directed cases plus random accesses vs a byte-lane model
module tb_ibex_load_store_resp;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0, q_req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic        req_sext = 1'b0;
  logic [1:0]  req_off = 2'b00;
  logic [4:0]  req_waddr = 5'd0;
  logic        rvalid = 1'b0, q_rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        rerr = 1'b0;

  logic        ready, valid, rf_we, load_err, store_err, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        q_ready, q_valid, q_rf_we, q_load_err, q_store_err, q_busy;
  logic [4:0]  q_rf_waddr;
  logic [31:0] q_rf_wdata;
`ifdef IBEX_LOAD_STORE_RESP_PERF_EN
  logic [31:0] perf_loads, perf_split, q_perf_loads, q_perf_split;
`endif

  int checks = 0;
  int failures = 0;
  int exp_loads = 0;
  int exp_split = 0;

  always #5 clk = ~clk;

  ibex_load_store_resp #(.MisalignedEn(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .ready_o(ready),
    .req_we_i(req_we), .req_type_i(req_type), .req_sign_ext_i(req_sext),
    .req_offset_i(req_off), .req_waddr_i(req_waddr), .data_rvalid_i(rvalid),
    .data_rdata_i(rdata), .data_err_i(rerr), .lsu_data_valid_o(valid),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .load_err_o(load_err), .store_err_o(store_err),
`ifdef IBEX_LOAD_STORE_RESP_PERF_EN
    .perf_loads_o(perf_loads), .perf_split_o(perf_split),
`endif
    .busy_o(busy)
  );

  ibex_load_store_resp #(.MisalignedEn(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(q_req_valid), .ready_o(q_ready),
    .req_we_i(req_we), .req_type_i(req_type), .req_sign_ext_i(req_sext),
    .req_offset_i(req_off), .req_waddr_i(req_waddr), .data_rvalid_i(q_rvalid),
    .data_rdata_i(rdata), .data_err_i(rerr), .lsu_data_valid_o(q_valid),
    .rf_we_o(q_rf_we), .rf_waddr_o(q_rf_waddr), .rf_wdata_o(q_rf_wdata),
    .load_err_o(q_load_err), .store_err_o(q_store_err),
`ifdef IBEX_LOAD_STORE_RESP_PERF_EN
    .perf_loads_o(q_perf_loads), .perf_split_o(q_perf_split),
`endif
    .busy_o(q_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] typ);
    return (typ == 2'b00) ? 4 : (typ == 2'b01) ? 2 : 1;
  endfunction

  // Memory view: the two response words are consecutive bytes; pick size bytes at the offset.
  function automatic logic [31:0] model_load(input logic [1:0] typ, input logic sext,
                                             input logic [1:0] off, input logic [31:0] r1,
                                             input logic [31:0] r2);
    logic [63:0] bytes;
    logic [31:0] v;
    bytes = {r2, r1} >> (8 * int'(off));
    v = bytes[31:0];
    case (size_of(typ))
      2:       v = sext ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
      1:       v = sext ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
      default: v = bytes[31:0];
    endcase
    return v;
  endfunction

  task automatic access(input logic we, input logic [1:0] typ, input logic sext,
                        input logic [1:0] off, input logic [4:0] wa,
                        input logic [31:0] r1, input logic e1,
                        input logic [31:0] r2, input logic e2, input int nw);
    bit split;
    logic err;
    logic [31:0] val;
    split = (int'(off) + size_of(typ)) > 4;
    err   = split ? (e1 | e2) : e1;
    val   = model_load(typ, sext, off, r1, r2);
    check("ready_before_req", {31'd0, ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_type = typ; req_sext = sext;
    req_off = off; req_waddr = wa;
    @(negedge clk);
    req_valid = 1'b0;
    check("pulse_one_cycle", {31'd0, valid}, 32'd0);
    check("busy_after_req", {31'd0, busy}, 32'd1);
    repeat (nw) @(negedge clk);
    rvalid = 1'b1; rdata = r1; rerr = e1;
    @(negedge clk);
    rvalid = 1'b0;
    if (split) begin
      check("no_pulse_after_first", {31'd0, valid}, 32'd0);
      repeat (nw) @(negedge clk);
      rvalid = 1'b1; rdata = r2; rerr = e2;
      @(negedge clk);
      rvalid = 1'b0;
      exp_split++;
    end
    check("pulse", {31'd0, valid}, 32'd1);
    check("ready_in_pulse", {31'd0, ready}, 32'd1);
    check("rf_we", {31'd0, rf_we}, {31'd0, ~we & ~err});
    check("load_err", {31'd0, load_err}, {31'd0, ~we & err});
    check("store_err", {31'd0, store_err}, {31'd0, we & err});
    if (!we && !err) begin
      check("rf_waddr", {27'd0, rf_waddr}, {27'd0, wa});
      check("rf_wdata", rf_wdata, val);
      exp_loads++;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_errs", {30'd0, load_err, store_err}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    access(1'b0, 2'b00, 1'b0, 2'd0, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 3);
    access(1'b0, 2'b10, 1'b1, 2'd2, 5'd7, 32'h0080_0000, 1'b0, 32'd0, 1'b0, 0);
    check("byte_sext", rf_wdata, 32'hFFFF_FF80);
    access(1'b0, 2'b11, 1'b0, 2'd2, 5'd7, 32'h0080_0000, 1'b0, 32'd0, 1'b0, 1);
    check("byte_zext", rf_wdata, 32'h0000_0080);
    access(1'b0, 2'b00, 1'b0, 2'd1, 5'd9, 32'h3322_11AA, 1'b0, 32'hBBCC_DD44, 1'b0, 2);
    check("split_word", rf_wdata, 32'h4433_2211);
    access(1'b0, 2'b01, 1'b1, 2'd3, 5'd3, 32'h1234_5678, 1'b1, 32'h9ABC_DEF0, 1'b0, 1);
    access(1'b1, 2'b00, 1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
             ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 2)));
    end

    // Split support disabled: half at offset 3 completes on the first response as an error.
    q_req_valid = 1'b1; req_we = 1'b0; req_type = 2'b01; req_off = 2'd3; req_waddr = 5'd4;
    @(negedge clk);
    q_req_valid = 1'b0;
    @(negedge clk);
    q_rvalid = 1'b1; rdata = 32'hAABB_CCDD; rerr = 1'b0;
    @(negedge clk);
    q_rvalid = 1'b0;
    check("nomis_pulse", {31'd0, q_valid}, 32'd1);
    check("nomis_load_err", {31'd0, q_load_err}, 32'd1);
    check("nomis_rf_we", {31'd0, q_rf_we}, 32'd0);
    check("nomis_ready", {31'd0, q_ready}, 32'd1);
    q_req_valid = 1'b1; req_type = 2'b00; req_off = 2'd0;
    @(negedge clk);
    q_req_valid = 1'b0;
    q_rvalid = 1'b1; rdata = 32'h0102_0304;
    @(negedge clk);
    q_rvalid = 1'b0;
    check("nomis_aligned_rf_we", {31'd0, q_rf_we}, 32'd1);
    check("nomis_aligned_data", q_rf_wdata, 32'h0102_0304);

`ifdef IBEX_LOAD_STORE_RESP_PERF_EN
    check("perf_loads", perf_loads, 32'(exp_loads));
    check("perf_split", perf_split, 32'(exp_split));
`endif

    // Reset while waiting for the second half of a split load.
    req_valid = 1'b1; req_we = 1'b0; req_type = 2'b00; req_off = 2'd2; req_waddr = 5'd1;
    @(negedge clk);
    req_valid = 1'b0;
    rvalid = 1'b1; rdata = 32'h1111_2222; rerr = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    check("wait2_busy", {31'd0, busy}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    exp_loads = 0;
    exp_split = 0;
    rvalid = 1'b1; rdata = 32'h3333_4444;
    @(negedge clk);
    rvalid = 1'b0;
    check("late_rvalid_no_pulse", {31'd0, valid}, 32'd0);
    check("late_rvalid_ready", {31'd0, ready}, 32'd1);

    access(1'b0, 2'b00, 1'b0, 2'd0, 5'd2, 32'h0000_0001, 1'b0, 32'd0, 1'b0, 0);
    access(1'b0, 2'b01, 1'b0, 2'd0, 5'd2, 32'h0000_8002, 1'b0, 32'd0, 1'b0, 1);
    access(1'b0, 2'b10, 1'b0, 2'd1, 5'd2, 32'h0000_0300, 1'b0, 32'd0, 1'b0, 0);
    access(1'b1, 2'b00, 1'b0, 2'd3, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1);
`ifdef IBEX_LOAD_STORE_RESP_PERF_EN
    check("perf_loads_after_rst", perf_loads, 32'd3);
    check("perf_split_after_rst", perf_split, 32'd1);
`endif
    @(negedge clk);
    check("idle_no_pulse", {31'd0, valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
